// File: rtl/cga_cpu_vram_port_pkg.sv
// Shared types and constants for the CGA CPU-side VRAM port.
package cga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_ACCESS,
    ST_CAPTURE,
    ST_DONE
  } vram_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } vram_op_e;

  localparam logic [19:0] CGA_FB_BASE = 20'hB8000;

  // 16K boards ignore a[14], so both halves of the window alias the same RAM.
  function automatic logic [18:0] vram_addr(input logic [14:0] a, input bit tandy);
    return {4'h0, (tandy ? a[14] : 1'b0), a[13:0]};
  endfunction

endpackage

// File: rtl/isa_strobe_sync.sv
// Two-flop synchronizer for an active-low ISA strobe with falling-edge detect.
module isa_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_l,
  output logic sync_l,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = strobe_l;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_l = sync_q;
  assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/cga_cpu_vram_port.sv
// CPU access port into CGA video RAM: waits for the sequencer slot, performs
// one read or write, and holds IOCHRDY low until the access completes.
module cga_cpu_vram_port
  import cga_pkg::*;
#(
  parameter int USE_BUS_WAIT = 1,
  parameter int TANDY_32K    = 0,
  parameter int SLOT_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic [14:0] bus_a,
  input  logic        bus_mem_cs,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  output logic        bus_rdy,
  input  logic        isa_op_enable,
  output logic        cpu_ram_sel,
  output logic [18:0] ram_a,
  output logic [7:0]  ram_d_out,
  input  logic [7:0]  ram_d_in,
  output logic        ram_we_l
);

  localparam int CW = (SLOT_TIMEOUT < 2) ? 1 : $clog2(SLOT_TIMEOUT + 1);

  logic memr_sync_l, memr_fall;
  logic memw_sync_l, memw_fall;

  isa_strobe_sync u_memr_sync (
    .clk      (clk),
    .rst_n    (nRESET),
    .strobe_l (bus_memr_l),
    .sync_l   (memr_sync_l),
    .fall     (memr_fall)
  );

  isa_strobe_sync u_memw_sync (
    .clk      (clk),
    .rst_n    (nRESET),
    .strobe_l (bus_memw_l),
    .sync_l   (memw_sync_l),
    .fall     (memw_fall)
  );

  vram_state_e state_q, state_d;
  vram_op_e    op_q, op_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  bus_out_q, bus_out_d;
  logic        bus_dir_q, bus_dir_d;
  logic        bus_rdy_q, bus_rdy_d;
  logic        sel_q, sel_d;
  logic [18:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_d_out_q, ram_d_out_d;
  logic        we_l_q, we_l_d;

  logic both_low;
  logic op_strobe_l;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    bus_out_d   = bus_out_q;
    bus_dir_d   = bus_dir_q;
    bus_rdy_d   = bus_rdy_q;
    sel_d       = sel_q;
    ram_a_d     = ram_a_q;
    ram_d_out_d = ram_d_out_q;
    we_l_d      = 1'b1;

    both_low    = ~memr_sync_l & ~memw_sync_l;
    op_strobe_l = (op_q == OP_WR) ? memw_sync_l : memr_sync_l;

    unique case (state_q)
      ST_IDLE: begin
        if (bus_mem_cs && !both_low) begin
          if (memw_fall) begin
            addr_d    = bus_a;
            wdata_d   = bus_d;
            op_d      = OP_WR;
            cnt_d     = '0;
            bus_rdy_d = 1'b0;
            state_d   = ST_WAIT_SLOT;
          end else if (memr_fall) begin
            addr_d    = bus_a;
            op_d      = OP_RD;
            cnt_d     = '0;
            bus_rdy_d = 1'b0;
            state_d   = ST_WAIT_SLOT;
          end
        end
      end
      ST_WAIT_SLOT: begin
        if (isa_op_enable) begin
          sel_d   = 1'b1;
          ram_a_d = vram_addr(addr_q, TANDY_32K != 0);
          if (op_q == OP_WR) begin
            we_l_d      = 1'b0;
            ram_d_out_d = wdata_q;
          end
          state_d = ST_ACCESS;
        end else if (cnt_q == CW'(SLOT_TIMEOUT)) begin
          // No slot arrived: release the bus with open-bus data, drop writes.
          bus_rdy_d = 1'b1;
          if (op_q == OP_RD) begin
            bus_out_d = 8'hFF;
            bus_dir_d = ~memr_sync_l;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACCESS: begin
        if (op_q == OP_WR) begin
          sel_d     = 1'b0;
          bus_rdy_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        bus_out_d = ram_d_in;
        bus_dir_d = ~memr_sync_l;
        sel_d     = 1'b0;
        bus_rdy_d = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (op_strobe_l) begin
          bus_dir_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          bus_dir_d = (op_q == OP_RD);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      bus_out_q   <= '0;
      bus_dir_q   <= 1'b0;
      bus_rdy_q   <= 1'b1;
      sel_q       <= 1'b0;
      ram_a_q     <= '0;
      ram_d_out_q <= '0;
      we_l_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      bus_out_q   <= bus_out_d;
      bus_dir_q   <= bus_dir_d;
      bus_rdy_q   <= bus_rdy_d;
      sel_q       <= sel_d;
      ram_a_q     <= ram_a_d;
      ram_d_out_q <= ram_d_out_d;
      we_l_q      <= we_l_d;
    end
  end

  assign bus_out     = bus_out_q;
  assign bus_dir     = bus_dir_q;
  assign bus_rdy     = (USE_BUS_WAIT != 0) ? bus_rdy_q : 1'b1;
  assign cpu_ram_sel = sel_q;
  assign ram_a       = ram_a_q;
  assign ram_d_out   = ram_d_out_q;
  assign ram_we_l    = we_l_q;

endmodule

// File: doc/cga_cpu_vram_port.md
Name: cga_cpu_vram_port

Overview:
- CPU-side writer/reader of CGA video RAM, the opposite end of the display fetch path.
- Accepts ISA memory cycles in the B8000–BFFFF window and waits for the sequencer's CPU slot (isa_op_enable).
- Performs one RAM write or read in that slot, holds bus_rdy low until the access completes, and returns read data on the ISA bus.
- Sits between the ISA decode and the VRAM address/data mux, beside the display fetch logic.

Parameters:
- USE_BUS_WAIT, 1: 1 = drive bus_rdy low during pending access; 0 = bus_rdy tied 1.
- TANDY_32K, 0: 1 = ram_a[14] from bus_a[14]; 0 = 16K mirrored, ram_a[14]=0.
- SLOT_TIMEOUT, 63: max clk cycles in WAIT_SLOT before forced completion.

Ports:
- clk  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- bus_a  in  15  offset within B8000 window
- bus_mem_cs  in  1  address decoded to CGA framebuffer window
- bus_memr_l  in  1  ISA memory read strobe, active low, asynchronous
- bus_memw_l  in  1  ISA memory write strobe, active low, asynchronous
- bus_d  in  8  ISA write data
- bus_out  out  8  read data to ISA
- bus_dir  out  1  1 = block drives ISA data bus
- bus_rdy  out  1  ISA IOCHRDY, 0 = wait
- isa_op_enable  in  1  one-clk CPU access slot pulse from sequencer
- cpu_ram_sel  out  1  1 = VRAM mux selects this port's address/data
- ram_a  out  19  VRAM address
- ram_d_out  out  8  VRAM write data
- ram_d_in  in  8  VRAM read data (valid one clk after address)
- ram_we_l  out  1  VRAM write enable, active low

Behaviour:
- Interface: one clock, clk; reset nRESET is asynchronous, active-low.
- Reset values: bus_out=00, bus_dir=0, bus_rdy=1, cpu_ram_sel=0, ram_we_l=1, ram_a=0, ram_d_out=0, state=IDLE, timeout counter=0.
- Strobe sync: bus_memr_l and bus_memw_l pass through 2 flops. A falling edge is detected on the synced value, so the internal strobe lags the pin by 2 clk.
- IDLE:
  - Synced memw fall with bus_mem_cs: latch address, bus_d, op=WR; go WAIT_SLOT; bus_rdy<=0.
  - Synced memr fall with bus_mem_cs: latch address, op=RD; go WAIT_SLOT; bus_rdy<=0.
  - Both strobes low together: protocol error; stay IDLE, no RAM access.
- WAIT_SLOT: counter increments each clk.
  - isa_op_enable=1: go ACCESS.
  - counter==SLOT_TIMEOUT: go DONE; read data = FF; write dropped.
- ACCESS (1 clk): cpu_ram_sel=1, ram_a={4'h0, TANDY_32K?a[14]:0, a[13:0]}.
  - WR: ram_we_l=0, ram_d_out=latched data; next state DONE.
  - RD: ram_we_l=1; next state CAPTURE.
- CAPTURE (1 clk, RD only): cpu_ram_sel held 1; bus_out<=ram_d_in; go DONE.
- DONE: bus_rdy=1.
  - RD: bus_dir=1 while synced memr low; bus_out held.
  - On synced strobe high: bus_dir=0, counter=0, go IDLE.
- Latency from detection to bus_rdy=1:
  - Slot in first WAIT_SLOT clk: write 2 clk, read 3 clk.
  - Worst case without timeout is one sequencer period.
- isa_op_enable in IDLE, CAPTURE or DONE is ignored. Only one access per strobe assertion.
- Strobe released before DONE (master ignored rdy): the access still completes. DONE then exits on the next clk.
- USE_BUS_WAIT=0: FSM unchanged, bus_rdy constantly 1. Read data may be stale; accepted.
- nRESET asserted mid-operation: immediate return to reset values; any pending write is lost. bus_rdy=1 asynchronously.
- ram_we_l is low only in ACCESS with op=WR; never two consecutive clk.

Decomposition:
- Shared package cga_pkg holds:
  - FSM state encoding: IDLE, WAIT_SLOT, ACCESS, CAPTURE, DONE.
  - CGA_FB_BASE=20'hB8000.
  - RD/WR op constants.
- One natural sub-module, isa_strobe_sync: 2-flop synchronizer plus falling-edge detect, instanced for memr and memw.

Test Plan:
- Write: memw low, a=0x0123, d=0x5A; isa_op_enable 5 clk after detection -> one clk with ram_we_l=0, ram_a=0x00123, ram_d_out=5A. bus_rdy low from detection to ACCESS+1.
- Read: RAM model returns 0xC3 at 0x1FFF; memr at a=0x1FFF -> bus_out=C3 and bus_dir=1 after CAPTURE; bus_dir=0 two clk after memr rises.
- Mirror: TANDY_32K=0, a=0x4010 -> ram_a=0x00010. TANDY_32K=1, same access -> ram_a=0x04010.
- Timeout: memr asserted, no isa_op_enable for 70 clk -> bus_rdy=1 at SLOT_TIMEOUT, bus_out=FF, no RAM access.
- Reset mid-op: nRESET low during WAIT_SLOT of a write -> bus_rdy=1 immediately, ram_we_l stays 1. After release, a new write completes normally.
- Protocol error / stray slot: memr and memw low together -> no state change. isa_op_enable pulses in IDLE -> cpu_ram_sel stays 0.
